// File: rtl/rx_byte_buffer_pkg.sv
// Shared constants for the UART receive and transmit byte buffers.
package rx_byte_buffer_pkg;
    localparam int UART_WIDTH  = 8;
    localparam int RXBUF_DEPTH = 8;
    localparam int RXBUF_AW    = 3;
    localparam int RXBUF_CW    = RXBUF_AW + 1;
endpackage

// File: rtl/rx_byte_buffer_fifo.sv
// Generic first-word-fall-through FIFO: head entry is visible on rdata_o while not empty.
module sync_fwft_fifo
    import rx_byte_buffer_pkg::*;
#(
    parameter int WIDTH = UART_WIDTH,
    parameter int DEPTH = RXBUF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    // A pop on a full FIFO frees the slot the simultaneous push writes into.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/rx_byte_buffer.sv
// UART receive byte queue: captures one byte per rx_rda rising edge into an FWFT FIFO
// and tracks a sticky overrun flag for bytes dropped while full.
module rx_byte_buffer
    import rx_byte_buffer_pkg::*;
#(
    parameter int WIDTH = UART_WIDTH,
    parameter int DEPTH = RXBUF_DEPTH,
    parameter int AW    = RXBUF_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_rda,
    input  logic             rd_en,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [AW:0]      count,
    output logic             full,
    output logic             overrun
);
    // Read handshake: a byte is consumed on an edge only when rd_en && rd_valid;
    // rd_en while rd_valid is low has no effect.
    logic             rda_q;
    logic             overrun_q, overrun_d;
    logic             push, pop, drop, empty;
    logic [WIDTH-1:0] head;

    assign push = rx_rda & ~rda_q;
    assign pop  = rd_en & rd_valid;
    assign drop = push & full & ~pop;

    always_comb begin
        overrun_d = overrun_q;
        if (drop)         overrun_d = 1'b1;
        else if (clr_ovr) overrun_d = 1'b0;
    end

    // rda_q resets high so a level already asserted at reset release is not a new byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rda_q     <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            rda_q     <= rx_rda;
            overrun_q <= overrun_d;
        end
    end

    sync_fwft_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (rx_data),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign rd_valid = ~empty;
    assign rd_data  = rd_valid ? head : '0;
    assign overrun  = overrun_q;
endmodule

// File: tb/tb_rx_byte_buffer.sv
// Directed bench for rx_byte_buffer: vector table plus scoreboarded interleaving and async reset.
module tb_rx_byte_buffer;
    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_rda;
    logic       rd_en;
    logic       clr_ovr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [3:0] count;
    logic       full;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rda;
        logic [7:0] data;
        logic       rd_en;
        logic       clr;
        logic [3:0] e_count;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_full;
        logic       e_ovr;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    logic       m_prev_rda;
    logic       m_ovr;

    rx_byte_buffer dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_rda   (rx_rda),
        .rd_en    (rd_en),
        .clr_ovr  (clr_ovr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count),
        .full     (full),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function void add_vec(input int rda, input int data, input int rde, input int clr,
                          input int ec, input int ev, input int ed, input int ef, input int eo);
        vec_t v;
        v.rda     = rda[0];
        v.data    = 8'(data);
        v.rd_en   = rde[0];
        v.clr     = clr[0];
        v.e_count = 4'(ec);
        v.e_valid = ev[0];
        v.e_data  = 8'(ed);
        v.e_full  = ef[0];
        v.e_ovr   = eo[0];
        vecs.push_back(v);
    endfunction

    function void add_fill();
        for (int i = 1; i <= 8; i++) begin
            add_vec(1, i, 0, 0, i, 1, 8'h01, (i == 8) ? 1 : 0, 0);
            add_vec(0, 0, 0, 0, i, 1, 8'h01, (i == 8) ? 1 : 0, 0);
        end
    endfunction

    function void build_vectors();
        // level held high out of reset: no capture
        for (int k = 0; k < 5; k++) add_vec(1, 8'h33, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_vec(1, 8'hA5, 0, 0, 1, 1, 8'hA5, 0, 0);
        add_vec(1, 8'h5A, 0, 0, 1, 1, 8'hA5, 0, 0);
        add_vec(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // fill then drain in order
        add_fill();
        for (int j = 1; j <= 8; j++)
            add_vec(0, 0, 1, 0, 8 - j, (j < 8) ? 1 : 0, (j < 8) ? j + 1 : 0, 0, 0);
        // overrun set, clear, set-wins-over-clear
        add_fill();
        add_vec(1, 8'hFF, 0, 0, 8, 1, 8'h01, 1, 1);
        add_vec(0, 0, 0, 0, 8, 1, 8'h01, 1, 1);
        add_vec(0, 0, 0, 1, 8, 1, 8'h01, 1, 0);
        add_vec(1, 8'hEE, 0, 1, 8, 1, 8'h01, 1, 1);
        add_vec(0, 0, 0, 1, 8, 1, 8'h01, 1, 0);
        // push and pop together while full
        add_vec(1, 8'h99, 1, 0, 8, 1, 8'h02, 1, 0);
        add_vec(0, 0, 0, 0, 8, 1, 8'h02, 1, 0);
        for (int j = 1; j <= 7; j++)
            add_vec(0, 0, 1, 0, 8 - j, 1, (j <= 6) ? j + 2 : 8'h99, 0, 0);
        add_vec(0, 0, 1, 0, 0, 0, 0, 0, 0);
        add_vec(0, 0, 1, 0, 0, 0, 0, 0, 0);
        add_vec(1, 8'h42, 0, 0, 1, 1, 8'h42, 0, 0);
        add_vec(0, 0, 1, 0, 0, 0, 0, 0, 0);
    endfunction

    // Drives one cycle and advances the queue model alongside the DUT.
    task automatic model_step(input logic rda, input logic [7:0] data, input logic rde,
                              input logic clr, input string tag);
        logic m_push, m_drop;
        m_push = rda & ~m_prev_rda;
        m_drop = 1'b0;
        if (rde && exp_q.size() > 0) void'(exp_q.pop_front());
        if (m_push) begin
            if (exp_q.size() < 8) exp_q.push_back(data);
            else                  m_drop = 1'b1;
        end
        if (m_drop)   m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        m_prev_rda = rda;
        rx_rda  = rda;
        rx_data = data;
        rd_en   = rde;
        clr_ovr = clr;
        tick();
        check({tag, " count"}, 32'(count), 32'(exp_q.size()));
        check({tag, " valid"}, 32'(rd_valid), (exp_q.size() > 0) ? 32'd1 : 32'd0);
        check({tag, " data"}, 32'(rd_data), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd0);
        check({tag, " ovr"}, 32'(overrun), 32'(m_ovr));
    endtask

    initial begin
        rst     = 1'b0;
        rx_rda  = 1'b1;
        rx_data = 8'h00;
        rd_en   = 1'b0;
        clr_ovr = 1'b0;
        build_vectors();

        repeat (3) tick();
        check("reset count", 32'(count), 32'd0);
        check("reset valid", 32'(rd_valid), 32'd0);
        check("reset data", 32'(rd_data), 32'd0);
        check("reset full", 32'(full), 32'd0);
        check("reset ovr", 32'(overrun), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            rx_rda  = vecs[i].rda;
            rx_data = vecs[i].data;
            rd_en   = vecs[i].rd_en;
            clr_ovr = vecs[i].clr;
            tick();
            check($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].e_count));
            check($sformatf("v%0d valid", i), 32'(rd_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d data", i), 32'(rd_data), 32'(vecs[i].e_data));
            check($sformatf("v%0d full", i), 32'(full), 32'(vecs[i].e_full));
            check($sformatf("v%0d ovr", i), 32'(overrun), 32'(vecs[i].e_ovr));
        end

        // interleaved traffic: 30 pushes wrap the pointers several times
        m_prev_rda = 1'b0;
        m_ovr      = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 60; c++) begin
            model_step((c % 2) == 0, 8'(8'h10 + c / 2),
                       (c < 20) ? ((c % 4) == 3) : ((c % 3) != 0), 1'b0,
                       $sformatf("mix%0d", c));
        end
        for (int c = 0; c < 9; c++) model_step(1'b0, 8'h00, 1'b1, 1'b0, $sformatf("drain%0d", c));

        // reach count=5 with overrun set, then reset asynchronously mid-cycle
        for (int c = 0; c < 9; c++) begin
            model_step(1'b1, 8'(8'hC0 + c), 1'b0, 1'b0, $sformatf("pre%0d", c));
            model_step(1'b0, 8'h00, 1'b0, 1'b0, $sformatf("pre%0d_lo", c));
        end
        for (int c = 0; c < 3; c++) model_step(1'b0, 8'h00, 1'b1, 1'b0, $sformatf("prepop%0d", c));
        rd_en = 1'b0;
        check("pre-reset count", 32'(count), 32'd5);
        check("pre-reset ovr", 32'(overrun), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async count", 32'(count), 32'd0);
        check("async valid", 32'(rd_valid), 32'd0);
        check("async ovr", 32'(overrun), 32'd0);
        check("async data", 32'(rd_data), 32'd0);
        tick();
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
